// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths, MEM-stage FSM encoding, MEM/WB bubble control.
// No logic; latency and backpressure do not apply.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_BUSY = 1'b1
  } ma_state_t;

  // {RegWrite, MemToReg} of a bubble
  localparam logic [1:0] WB_CTL_BUBBLE = 2'b00;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: 1-cycle latency; bubble clears control, holds data.
// No backpressure of its own; the MEM stage decides load vs bubble each cycle.
module mem_wb_reg #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_bubble,
  input  logic              i_rdata_en,
  input  logic              i_regwrite,
  input  logic              i_memtoreg,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_aluout,
  input  logic [REG_W-1:0]  i_wreg,
  output logic              o_regwrite,
  output logic              o_memtoreg,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_aluout,
  output logic [REG_W-1:0]  o_wreg
);
  import mips_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_regwrite <= 1'b0;
      o_memtoreg <= 1'b0;
      o_rdata    <= '0;
      o_aluout   <= '0;
      o_wreg     <= '0;
    end else if (i_bubble) begin
      {o_regwrite, o_memtoreg} <= WB_CTL_BUBBLE;
    end else if (i_en) begin
      o_regwrite <= i_regwrite;
      o_memtoreg <= i_memtoreg;
      o_aluout   <= i_aluout;
      o_wreg     <= i_wreg;
      // read data is only meaningful for completed loads
      if (i_rdata_en) o_rdata <= i_rdata;
    end
  end
endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: data-memory req/ready access, W results 1 cycle after completion (N waits -> N+1).
// Stalls upstream via StallM while a request is outstanding; ALIGN_CHECK_EN enables misaligned-access trapping.
module memory_access #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              MemWriteM,
  input  logic              FlushM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              StallM,
  output logic              AddrErrM,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW
);
  import mips_pkg::*;

  ma_state_t          r_state, w_state_nxt;
  logic               r_we, r_regwrite, r_memtoreg;
  logic [DATA_W-1:0]  r_addr, r_wdata;
  logic [REG_W-1:0]   r_wreg;

  logic               w_req_any, w_misal, w_memop, w_load, w_regwrite;
  logic               w_latch, w_wb_bubble, w_wb_rdata_en, w_wb_regwrite, w_wb_memtoreg;
  logic [DATA_W-1:0]  w_wb_aluout;
  logic [REG_W-1:0]   w_wb_wreg;

  assign w_req_any  = (MemToRegM | MemWriteM) & ~FlushM;
  assign w_load     = MemToRegM & ~MemWriteM;
  // load+store together is treated as a store that never writes the register file
  assign w_regwrite = RegWriteM & ~(MemToRegM & MemWriteM);

`ifdef ALIGN_CHECK_EN
  assign w_misal  = w_req_any & (ALUOutM[1:0] != 2'b00);
  assign AddrErrM = rst_n & (r_state == MA_IDLE) & w_misal;
`else
  assign w_misal  = 1'b0;
  assign AddrErrM = 1'b0;
`endif

  assign w_memop = w_req_any & ~w_misal;

  always_comb begin
    w_state_nxt   = r_state;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
    StallM        = 1'b0;
    w_latch       = 1'b0;
    w_wb_bubble   = 1'b0;
    w_wb_rdata_en = 1'b0;
    w_wb_regwrite = w_regwrite;
    w_wb_memtoreg = w_load;
    w_wb_aluout   = ALUOutM;
    w_wb_wreg     = WriteRegM;
    // reset gating keeps the request and stall low the instant rst_n falls
    if (rst_n) begin
      case (r_state)
        MA_IDLE: begin
          if (FlushM || w_misal) w_wb_bubble = 1'b1;
          if (w_memop) begin
            dmem_req      = 1'b1;
            dmem_we       = MemWriteM;
            dmem_addr     = ALUOutM;
            dmem_wdata    = WriteDataM;
            w_wb_rdata_en = w_load;
            if (!dmem_ready) begin
              StallM      = 1'b1;
              w_latch     = 1'b1;
              w_wb_bubble = 1'b1;
              w_state_nxt = MA_BUSY;
            end
          end
        end
        MA_BUSY: begin
          dmem_req      = 1'b1;
          dmem_we       = r_we;
          dmem_addr     = r_addr;
          dmem_wdata    = r_wdata;
          w_wb_regwrite = r_regwrite;
          w_wb_memtoreg = r_memtoreg;
          w_wb_aluout   = r_addr;
          w_wb_wreg     = r_wreg;
          w_wb_rdata_en = r_memtoreg;
          if (dmem_ready) begin
            w_state_nxt = MA_IDLE;
          end else begin
            StallM      = 1'b1;
            w_wb_bubble = 1'b1;
          end
        end
        default: w_state_nxt = MA_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MA_IDLE;
      r_we       <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wreg     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_we       <= MemWriteM;
        r_regwrite <= w_regwrite;
        r_memtoreg <= w_load;
        r_addr     <= ALUOutM;
        r_wdata    <= WriteDataM;
        r_wreg     <= WriteRegM;
      end
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mem_wb_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (1'b1),
    .i_bubble   (w_wb_bubble),
    .i_rdata_en (w_wb_rdata_en),
    .i_regwrite (w_wb_regwrite),
    .i_memtoreg (w_wb_memtoreg),
    .i_rdata    (dmem_rdata),
    .i_aluout   (w_wb_aluout),
    .i_wreg     (w_wb_wreg),
    .o_regwrite (RegWriteW),
    .o_memtoreg (MemToRegW),
    .o_rdata    (ReadDataW),
    .o_aluout   (ALUOutW),
    .o_wreg     (WriteRegW)
  );
endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access against a per-instruction reference model with a word memory.
// Honours ALIGN_CHECK_EN the same way as the RTL build.
module tb_memory_access;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWriteM = 0, MemToRegM = 0, MemWriteM = 0, FlushM = 0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0;
  logic [4:0]  WriteRegM = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        StallM, AddrErrM, RegWriteW, MemToRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rdata = '0, exp_alu = '0;
  logic [4:0]  exp_wreg = '0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .FlushM(FlushM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .AddrErrM(AddrErrM),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_w(input string tag, input logic rw, input logic m2r);
    check_eq({tag, ".RegWriteW"}, RegWriteW, rw);
    check_eq({tag, ".MemToRegW"}, MemToRegW, m2r);
    check_eq({tag, ".ReadDataW"}, ReadDataW, exp_rdata);
    check_eq({tag, ".ALUOutW"},   ALUOutW,   exp_alu);
    check_eq({tag, ".WriteRegW"}, WriteRegW, exp_wreg);
  endtask

  // One instruction in MEM; entered and left at 1 time unit after a rising edge.
  task automatic run_instr(input string tag, input logic rw, input logic ld, input logic st,
                           input logic fl, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] wr, input int waits, input bit flush_in_busy);
    bit          is_mem = (ld | st) & ~fl;
    bit          misal  = ALIGN_ON && is_mem && (addr[1:0] != 2'b00);
    bit          memop  = is_mem && !misal;
    int          nw     = memop ? waits : 0;
    logic [31:0] rd     = mem_rd(addr);
    for (int c = 0; c <= nw; c++) begin
      if (c == 0) begin
        RegWriteM = rw; MemToRegM = ld; MemWriteM = st; FlushM = fl;
        ALUOutM = addr; WriteDataM = wd; WriteRegM = wr;
      end else begin
        // an issued access must use its captured copy, whatever the inputs do
        RegWriteM = 1'($urandom); MemToRegM = 1'($urandom); MemWriteM = 1'($urandom);
        FlushM = flush_in_busy ? 1'b1 : 1'($urandom);
        ALUOutM = $urandom; WriteDataM = $urandom; WriteRegM = 5'($urandom);
      end
      dmem_ready = memop ? (c == nw) : 1'($urandom);
      dmem_rdata = (memop && !st && c == nw) ? rd : $urandom;
      #1;
      check_eq({tag, ".req"},    dmem_req, memop);
      check_eq({tag, ".stall"},  StallM,   memop && (c < nw));
      check_eq({tag, ".addrerr"}, AddrErrM, misal);
      if (memop) begin
        check_eq({tag, ".addr"},  dmem_addr,  addr);
        check_eq({tag, ".we"},    dmem_we,    st);
        check_eq({tag, ".wdata"}, dmem_wdata, wd);
      end
      @(posedge clk); #1;
      if (c < nw) check_w({tag, ".wait"}, 1'b0, 1'b0);
    end
    if (memop && st) mem[addr] = wd;
    if (fl || misal) begin
      check_w({tag, ".bubble"}, 1'b0, 1'b0);
    end else begin
      exp_alu  = addr;
      exp_wreg = wr;
      if (ld && !st) exp_rdata = rd;
      check_w({tag, ".retire"}, rw & ~(ld & st), ld & ~st);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic go_idle();
    RegWriteM = 0; MemToRegM = 0; MemWriteM = 0; FlushM = 0;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0; dmem_ready = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.req", dmem_req, 1'b0);
    check_eq("rst.stall", StallM, 1'b0);
    check_eq("rst.addrerr", AddrErrM, 1'b0);
    check_w("rst", 1'b0, 1'b0);
    rst_n = 1'b1;

    // zero-wait load
    mem[32'h100] = 32'hDEAD_BEEF;
    run_instr("ldz", 1, 1, 0, 0, 32'h100, 32'h0, 5'd8, 0, 0);

    // reset asserted while an access is outstanding
    RegWriteM = 1; MemToRegM = 1; ALUOutM = 32'h40; WriteRegM = 5'd3; dmem_ready = 0;
    @(posedge clk); #1;
    check_eq("rstbusy.stall_before", StallM, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstbusy.req", dmem_req, 1'b0);
    check_eq("rstbusy.stall", StallM, 1'b0);
    exp_rdata = '0; exp_alu = '0; exp_wreg = '0;
    check_w("rstbusy", 1'b0, 1'b0);
    @(posedge clk); #1;
    go_idle();
    rst_n = 1'b1;

    // store with three wait states
    run_instr("st3", 0, 0, 1, 0, 32'h200, 32'h1234_5678, 5'd0, 3, 0);
    // flush in IDLE, then flush held high while BUSY
    run_instr("flidle", 1, 1, 0, 1, 32'h300, 32'h0, 5'd9, 2, 0);
    run_instr("flbusy", 1, 1, 0, 0, 32'h200, 32'h0, 5'd10, 2, 1);
    // back-to-back zero-wait loads
    run_instr("b2b0", 1, 1, 0, 0, 32'h10, 32'h0, 5'd11, 0, 0);
    run_instr("b2b1", 1, 1, 0, 0, 32'h14, 32'h0, 5'd12, 0, 0);
    // misaligned load
    run_instr("misal", 1, 1, 0, 0, 32'h102, 32'h0, 5'd13, 1, 0);
    // load and store together, then a plain ALU op
    run_instr("ldst", 1, 1, 1, 0, 32'h24, 32'hCAFE_F00D, 5'd14, 1, 0);
    run_instr("alu", 1, 0, 0, 0, 32'h7777_0001, 32'h0, 5'd15, 0, 0);

    for (int i = 0; i < 300; i++) begin
      int          kind  = $urandom_range(0, 5);
      logic [31:0] addr  = {24'h0, 6'($urandom), 2'b00};
      logic        rw    = 1'($urandom);
      logic        ld    = (kind == 1 || kind == 2 || kind == 4) ? 1'b1 : 1'($urandom) & (kind == 5);
      logic        st    = (kind == 3 || kind == 4) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom);
      if (kind == 0) addr = $urandom;
      run_instr("rnd", rw, ld, st, kind == 5, addr, $urandom, 5'($urandom),
                $urandom_range(0, 3), 1'($urandom));
    end

    go_idle();
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
